// File: rtl/control_escritura_banco.sv
// Write-port controller for the register bank: synchronizes and debounces the write button,
// captures address/data from the switches and issues one write strobe per press. Optional macro: PROTECT_X0_EN.
module control_escritura_banco #(
  parameter int N               = 4,
  parameter int M               = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_we_raw,
  input  logic [M-1:0] addr_rd_sw,
  input  logic [N-1:0] data_sw,
  output logic [M-1:0] addr_rd,
  output logic [N-1:0] data_in,
  output logic         we,
  output logic         busy,
  output logic [7:0]   wr_count,
  output logic         rechazo
);

  typedef enum logic [1:0] {IDLE, ARM, WRITE, REL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               sync1_reg, sync2_reg;
  logic               btn_s;
  logic               capture;
  logic               addr_zero;
  logic               we_next, rechazo_next;
  logic [M-1:0]       addr_reg;
  logic [N-1:0]       data_reg;
  logic               we_reg, rechazo_reg;
  logic [7:0]         wr_count_reg;

  assign btn_s     = sync2_reg;
  assign addr_zero = (addr_rd_sw == '0);

  // Two-flop synchronizer; only the button crosses in asynchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_we_raw;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = ARM;
          cnt_next   = '0;
        end
      end
      ARM: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = WRITE;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WRITE: begin
        state_next = REL;
        cnt_next   = '0;
      end
      REL: begin
        // Any bounce high restarts the release window, so a held button never re-arms.
        if (btn_s) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef PROTECT_X0_EN
  // Address 0 is a hard-wired zero register: the write is swallowed and flagged.
  assign we_next      = capture && !addr_zero;
  assign rechazo_next = capture && addr_zero;
`else
  assign we_next      = capture;
  assign rechazo_next = 1'b0;
`endif

  // Strobes are registered on the edge entering WRITE so they are high exactly for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= '0;
      data_reg     <= '0;
      we_reg       <= 1'b0;
      rechazo_reg  <= 1'b0;
      wr_count_reg <= 8'd0;
    end else begin
      if (capture) begin
        addr_reg <= addr_rd_sw;
        data_reg <= data_sw;
      end
      we_reg      <= we_next;
      rechazo_reg <= rechazo_next;
      if (we_reg) begin
        wr_count_reg <= wr_count_reg + 8'd1;
      end
    end
  end

  assign addr_rd  = addr_reg;
  assign data_in  = data_reg;
  assign we       = we_reg;
  assign rechazo  = rechazo_reg;
  assign wr_count = wr_count_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_control_escritura_banco.sv
// Directed bench for control_escritura_banco with an 8-cycle debounce window.
module tb_control_escritura_banco;

  localparam int N = 4;
  localparam int M = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_we_raw;
  logic [M-1:0] addr_rd_sw;
  logic [N-1:0] data_sw;
  logic [M-1:0] addr_rd;
  logic [N-1:0] data_in;
  logic         we;
  logic         busy;
  logic [7:0]   wr_count;
  logic         rechazo;

  int checks = 0;
  int passes = 0;
  int we_cnt = 0;
  int rech_cnt = 0;

  control_escritura_banco #(
    .N(N), .M(M), .DEBOUNCE_CYCLES(D), .CNT_W(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_we_raw (btn_we_raw),
    .addr_rd_sw (addr_rd_sw),
    .data_sw    (data_sw),
    .addr_rd    (addr_rd),
    .data_in    (data_in),
    .we         (we),
    .busy       (busy),
    .wr_count   (wr_count),
    .rechazo    (rechazo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles, tallying strobe cycles seen after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (we === 1'b1) we_cnt++;
      if (rechazo === 1'b1) rech_cnt++;
    end
  endtask

  task automatic press();
    btn_we_raw = 1'b1;
    run(12);
    btn_we_raw = 1'b0;
    run(11);
  endtask

  initial begin
    rst = 1'b1; btn_we_raw = 1'b0; addr_rd_sw = 4'd5; data_sw = 4'hA;

    // Reset state
    tick(); tick();
    check("rst_addr", 32'(addr_rd), 32'd0);
    check("rst_data", 32'(data_in), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(wr_count), 32'd0);
    check("rst_rech", 32'(rechazo), 32'd0);
    rst = 1'b0;
    $display("T1 reset checked");

    // Test 1: latency D+3 edges; we high only after edge 10 (tick 11)
    btn_we_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("t1_we_%0d", i), 32'(we), 32'(i == 11));
      if (i == 2) check("t1_busy_pre", 32'(busy), 32'd0);
      if (i == 3) check("t1_busy_on", 32'(busy), 32'd1);
    end
    check("t1_addr", 32'(addr_rd), 32'd5);
    check("t1_data", 32'(data_in), 32'hA);
    check("t1_cnt", 32'(wr_count), 32'd1);
    btn_we_raw = 1'b0;
    run(9);
    check("t1_busy_rel", 32'(busy), 32'd1);
    run(1);
    check("t1_busy_off", 32'(busy), 32'd0);
    $display("T1 single write addr=%0d data=%0h count=%0d", addr_rd, data_in, wr_count);

    // Test 2: short press rejected, then glitchy 40-cycle hold gives one write
    we_cnt = 0;
    btn_we_raw = 1'b1; run(5);
    btn_we_raw = 1'b0; run(20);
    check("t2_short_we", 32'(we_cnt), 32'd0);
    check("t2_short_cnt", 32'(wr_count), 32'd1);
    check("t2_short_busy", 32'(busy), 32'd0);
    btn_we_raw = 1'b1; run(5);
    btn_we_raw = 1'b0; run(3);
    btn_we_raw = 1'b1; run(14);
    btn_we_raw = 1'b0; run(3);
    btn_we_raw = 1'b1; run(15);
    btn_we_raw = 1'b0; run(20);
    check("t2_glitch_we", 32'(we_cnt), 32'd1);
    check("t2_glitch_cnt", 32'(wr_count), 32'd2);
    check("t2_glitch_busy", 32'(busy), 32'd0);
    $display("T2 glitch hold we_pulses=%0d count=%0d", we_cnt, wr_count);

    // Test 3: long hold, switch change after capture has no effect
    we_cnt = 0; addr_rd_sw = 4'd7; data_sw = 4'hA;
    btn_we_raw = 1'b1; run(12);
    data_sw = 4'h3; addr_rd_sw = 4'd2; run(88);
    check("t3_we", 32'(we_cnt), 32'd1);
    check("t3_data_hold", 32'(data_in), 32'hA);
    check("t3_addr_hold", 32'(addr_rd), 32'd7);
    btn_we_raw = 1'b0; run(20);
    check("t3_data_rel", 32'(data_in), 32'hA);
    check("t3_cnt", 32'(wr_count), 32'd3);
    $display("T3 long hold we_pulses=%0d data=%0h", we_cnt, data_in);

    // Test 4: reset during WRITE, button held through reset
    we_cnt = 0; addr_rd_sw = 4'd9; data_sw = 4'h6;
    btn_we_raw = 1'b1; run(11);
    check("t4_we_pre", 32'(we), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t4_rst_we", 32'(we), 32'd0);
    check("t4_rst_addr", 32'(addr_rd), 32'd0);
    check("t4_rst_cnt", 32'(wr_count), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    we_cnt = 0;
    run(10);
    check("t4_no_early_we", 32'(we_cnt), 32'd0);
    run(1);
    check("t4_rewrite_we", 32'(we), 32'd1);
    check("t4_rewrite_addr", 32'(addr_rd), 32'd9);
    btn_we_raw = 1'b0; run(20);
    check("t4_cnt", 32'(wr_count), 32'd1);
    $display("T4 reset mid-write count=%0d", wr_count);

    // Test 5: counter wrap
    rst = 1'b1; tick(); rst = 1'b0;
    we_cnt = 0; addr_rd_sw = 4'd3; data_sw = 4'h1;
    for (int p = 0; p < 256; p++) press();
    check("t5_pulses", 32'(we_cnt), 32'd256);
    check("t5_wrap", 32'(wr_count), 32'd0);
    press();
    check("t5_after_wrap", 32'(wr_count), 32'd1);
    $display("T5 wrap count=%0d pulses=%0d", wr_count, we_cnt);

    // Test 6: write to address 0
    we_cnt = 0; rech_cnt = 0; addr_rd_sw = 4'd0; data_sw = 4'hF;
    press();
`ifdef PROTECT_X0_EN
    check("t6_we", 32'(we_cnt), 32'd0);
    check("t6_rech", 32'(rech_cnt), 32'd1);
    check("t6_cnt", 32'(wr_count), 32'd1);
`else
    check("t6_we", 32'(we_cnt), 32'd1);
    check("t6_rech", 32'(rech_cnt), 32'd0);
    check("t6_cnt", 32'(wr_count), 32'd2);
`endif
    check("t6_addr", 32'(addr_rd), 32'd0);
    check("t6_data", 32'(data_in), 32'hF);
    check("t6_busy", 32'(busy), 32'd0);
    $display("T6 addr0 we_pulses=%0d rechazo_pulses=%0d count=%0d", we_cnt, rech_cnt, wr_count);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
